// File: rtl/filter_ctrl_pkg.sv
// filter_ctrl_pkg
//   Types and constants shared by frame_sync_filter_ctrl and the filter mux.
//   filter_t     : filter selection encoding (COLOUR, BLUR, BRIGHTNESS, EDGES)
//   ctrl_state_t : framing FSM state (GAP, FRAME)
//   FRAME_CNT_W  : width of the completed-frame counter
package filter_ctrl_pkg;

    typedef enum logic [1:0] {
        COLOUR     = 2'd0,
        BLUR       = 2'd1,
        BRIGHTNESS = 2'd2,
        EDGES      = 2'd3
    } filter_t;

    typedef enum logic {
        GAP   = 1'b0,
        FRAME = 1'b1
    } ctrl_state_t;

    localparam int FRAME_CNT_W = 16;

endpackage

// File: rtl/flag_hysteresis.sv
// flag_hysteresis
//   Debounces the audio band flag across frame boundaries. On every commit
//   strobe the raw flag is sampled; the committed flag only follows once the
//   same value has been seen on FLAG_HOLD_FRAMES consecutive boundaries.
// Ports
//   clk, reset : clock, synchronous active-high reset
//   commit     : frame-boundary strobe, one cycle
//   flag_in    : raw flag sampled on commit
//   flag_out   : committed flag (registered)
module flag_hysteresis #(
    parameter int FLAG_HOLD_FRAMES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       commit,
    input  logic [1:0] flag_in,
    output logic [1:0] flag_out
);

    localparam int               HOLD_W   = $clog2(FLAG_HOLD_FRAMES + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(FLAG_HOLD_FRAMES);

    logic [1:0]        cand, cand_nxt;
    logic [HOLD_W-1:0] hold, hold_nxt;

    // Hold saturates at the threshold; larger counts carry no extra meaning.
    always_comb begin
        cand_nxt = cand;
        hold_nxt = hold;
        if (flag_in == cand) begin
            if (hold < HOLD_MAX)
                hold_nxt = hold + HOLD_W'(1);
        end else begin
            cand_nxt = flag_in;
            hold_nxt = HOLD_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cand     <= 2'd0;
            hold     <= '0;
            flag_out <= 2'd0;
        end else if (commit) begin
            cand <= cand_nxt;
            hold <= hold_nxt;
            // Threshold is judged on the count including this boundary.
            if (hold_nxt >= HOLD_MAX)
                flag_out <= cand_nxt;
        end
    end

endmodule

// File: rtl/frame_sync_filter_ctrl.sv
// frame_sync_filter_ctrl
//   Owns the filter mux configuration (filter_num, freq_flag) and only
//   changes it at frame boundaries, i.e. on the edge an eop beat is accepted
//   on the monitored mux input stream. Requests and the audio flag are
//   absorbed at any time and applied at the next boundary.
//   Optional auto-cycle (macro FILTER_AUTO_CYCLE_EN): with auto_mode high the
//   filter advances every FRAMES_PER_STEP completed frames.
// Ports
//   clk, reset                  : clock, synchronous active-high reset
//   req_valid, req_filter       : one-cycle filter change request
//   auto_mode                   : auto-cycle enable (ignored without macro)
//   freq_flag_in                : raw audio band flag
//   mon_valid/ready/sop/eop     : passively observed stream handshake
//   filter_num, freq_flag       : committed configuration
//   in_frame                    : between accepted sop and accepted eop
//   frame_done, proto_err       : one-cycle pulses
//   frame_cnt                   : completed frames, wrapping
module frame_sync_filter_ctrl
    import filter_ctrl_pkg::*;
#(
    parameter int FRAMES_PER_STEP  = 60,
    parameter int FLAG_HOLD_FRAMES = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_valid,
    input  logic [1:0]             req_filter,
    input  logic                   auto_mode,
    input  logic [1:0]             freq_flag_in,
    input  logic                   mon_valid,
    input  logic                   mon_ready,
    input  logic                   mon_sop,
    input  logic                   mon_eop,
    output logic [1:0]             filter_num,
    output logic [1:0]             freq_flag,
    output logic                   in_frame,
    output logic                   frame_done,
    output logic                   proto_err,
    output logic [FRAME_CNT_W-1:0] frame_cnt
);

    ctrl_state_t state, state_nxt;
    logic        accept, commit, perr;
    logic        pend_v;
    logic [1:0]  pend_val;
    logic        req_hit;
    logic [1:0]  req_sel;
    logic        auto_step;
    filter_t     filter_q;

    assign accept = mon_valid & mon_ready;

    // A request landing on the commit cycle bypasses the pending register.
    assign req_hit = req_valid | pend_v;
    assign req_sel = req_valid ? req_filter : pend_val;

    // Framing FSM. Violations pulse proto_err and leave the state alone.
    always_ff @(posedge clk) begin
        if (reset) state <= GAP;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        commit    = 1'b0;
        perr      = 1'b0;
        if (accept) begin
            case (state)
                GAP: begin
                    if (mon_sop && mon_eop) commit = 1'b1;       // one-beat frame
                    else if (mon_sop)       state_nxt = FRAME;
                    else if (mon_eop)       perr = 1'b1;         // stray eop
                end
                FRAME: begin
                    if (mon_sop) perr = 1'b1;                    // nested sop, eop ignored
                    else if (mon_eop) begin
                        commit    = 1'b1;
                        state_nxt = GAP;
                    end
                end
                default: state_nxt = GAP;
            endcase
        end
    end

`ifdef FILTER_AUTO_CYCLE_EN
    localparam int               STEP_W    = $clog2(FRAMES_PER_STEP + 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(FRAMES_PER_STEP - 1);

    logic [STEP_W-1:0] step_cnt;

    assign auto_step = auto_mode && (step_cnt == STEP_LAST);

    // Counts boundaries since the last filter change; any change restarts it.
    always_ff @(posedge clk) begin
        if (reset)
            step_cnt <= '0;
        else if (commit) begin
            if (req_hit || auto_step) step_cnt <= '0;
            else                      step_cnt <= step_cnt + STEP_W'(1);
        end
    end
`else
    logic unused_auto_mode;
    assign unused_auto_mode = auto_mode;
    assign auto_step        = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_v     <= 1'b0;
            pend_val   <= 2'd0;
            filter_q   <= COLOUR;
            frame_cnt  <= '0;
            frame_done <= 1'b0;
            proto_err  <= 1'b0;
        end else begin
            frame_done <= commit;
            proto_err  <= perr;
            if (commit) begin
                pend_v    <= 1'b0;
                frame_cnt <= frame_cnt + FRAME_CNT_W'(1);
                if (req_hit)        filter_q <= filter_t'(req_sel);
                else if (auto_step) filter_q <= filter_t'(filter_q + 2'd1);
            end else if (req_valid) begin
                pend_v   <= 1'b1;
                pend_val <= req_filter;
            end
        end
    end

    flag_hysteresis #(
        .FLAG_HOLD_FRAMES (FLAG_HOLD_FRAMES)
    ) u_flag_hyst (
        .clk      (clk),
        .reset    (reset),
        .commit   (commit),
        .flag_in  (freq_flag_in),
        .flag_out (freq_flag)
    );

    assign filter_num = filter_q;
    assign in_frame   = (state == FRAME);

endmodule

// File: tb/tb_frame_sync_filter_ctrl.sv
module tb_frame_sync_filter_ctrl;

    localparam int FPS = 3;
    localparam int FHF = 2;
`ifdef FILTER_AUTO_CYCLE_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, req_valid, auto_mode;
    logic [1:0]  req_filter, freq_flag_in;
    logic        mon_valid, mon_ready, mon_sop, mon_eop;
    logic [1:0]  filter_num, freq_flag;
    logic        in_frame, frame_done, proto_err;
    logic [15:0] frame_cnt;

    always #5 clk = ~clk;

    frame_sync_filter_ctrl #(
        .FRAMES_PER_STEP  (FPS),
        .FLAG_HOLD_FRAMES (FHF)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_filter   (req_filter),
        .auto_mode    (auto_mode),
        .freq_flag_in (freq_flag_in),
        .mon_valid    (mon_valid),
        .mon_ready    (mon_ready),
        .mon_sop      (mon_sop),
        .mon_eop      (mon_eop),
        .filter_num   (filter_num),
        .freq_flag    (freq_flag),
        .in_frame     (in_frame),
        .frame_done   (frame_done),
        .proto_err    (proto_err),
        .frame_cnt    (frame_cnt)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model: frames as a boolean "inside a frame", the request as an
    // optional value, flag history as the list of boundary samples.
    bit m_frame, m_pend_v, m_done, m_err;
    int m_pend, m_filter, m_flag, m_cnt, m_since;
    int m_hist[$];

    task automatic model_step();
        bit acc, boundary;
        int run;
        if (reset) begin
            m_frame = 0; m_pend_v = 0; m_done = 0; m_err = 0;
            m_pend = 0; m_filter = 0; m_flag = 0; m_cnt = 0; m_since = 0;
            m_hist.delete();
            return;
        end
        acc = mon_valid && mon_ready;
        boundary = 0;
        m_err = 0;
        if (acc) begin
            if (!m_frame) begin
                if (mon_sop && mon_eop) boundary = 1;
                else if (mon_sop)       m_frame = 1;
                else if (mon_eop)       m_err = 1;
            end else begin
                if (mon_sop) m_err = 1;
                else if (mon_eop) begin boundary = 1; m_frame = 0; end
            end
        end
        m_done = boundary;
        if (boundary) begin
            if (req_valid || m_pend_v) begin
                m_filter = req_valid ? int'(req_filter) : m_pend;
                m_since  = 0;
            end else begin
                m_since++;
                if (AUTO && auto_mode && m_since == FPS) begin
                    m_filter = (m_filter + 1) % 4;
                    m_since  = 0;
                end
            end
            m_pend_v = 0;
            m_hist.push_back(int'(freq_flag_in));
            run = 0;
            for (int i = m_hist.size() - 1; i >= 0; i--) begin
                if (m_hist[i] != m_hist[m_hist.size() - 1]) break;
                run++;
            end
            if (run >= FHF) m_flag = m_hist[m_hist.size() - 1];
            m_cnt = (m_cnt + 1) % 65536;
        end else if (req_valid) begin
            m_pend   = int'(req_filter);
            m_pend_v = 1;
        end
    endtask

    task automatic check_all();
        chk("filter_num", filter_num, m_filter);
        chk("freq_flag",  freq_flag,  m_flag);
        chk("in_frame",   in_frame,   m_frame);
        chk("frame_done", frame_done, m_done);
        chk("proto_err",  proto_err,  m_err);
        chk("frame_cnt",  frame_cnt,  m_cnt);
    endtask

    // One clock: drive, let the DUT and model take the edge, check at negedge.
    task automatic cyc(input bit v, input bit r, input bit s, input bit e,
                       input bit rq, input logic [1:0] rf, input logic [1:0] fl);
        mon_valid = v; mon_ready = r; mon_sop = s; mon_eop = e;
        req_valid = rq; req_filter = rf; freq_flag_in = fl;
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 2'd0, 2'd0);
    endtask

    task automatic frame1(input bit rq, input logic [1:0] rf, input logic [1:0] fl);
        cyc(1, 1, 1, 1, rq, rf, fl);
    endtask

    task automatic do_reset();
        reset = 1;
        idle();
        reset = 0;
    endtask

    initial begin
        reset = 1; auto_mode = 0;
        mon_valid = 0; mon_ready = 0; mon_sop = 0; mon_eop = 0;
        req_valid = 0; req_filter = 0; freq_flag_in = 0;
        @(negedge clk);
        idle();
        idle();
        chk("rst_filter", filter_num, 0);
        chk("rst_flag",   freq_flag,  0);
        chk("rst_cnt",    frame_cnt,  0);
        chk("rst_inframe", in_frame,  0);
        reset = 0;

        // Request mid-frame
        cyc(1, 1, 1, 0, 0, 2'd0, 2'd0);
        chk("t1_inframe", in_frame, 1);
        cyc(0, 0, 0, 0, 1, 2'd1, 2'd0);
        cyc(1, 1, 0, 0, 0, 2'd0, 2'd0);
        chk("t1_hold", filter_num, 0);
        cyc(1, 1, 0, 1, 0, 2'd0, 2'd0);
        chk("t1_filter", filter_num, 1);
        chk("t1_cnt", frame_cnt, 1);
        chk("t1_done", frame_done, 1);
        idle();
        chk("t1_done_pulse", frame_done, 0);

        // Two requests in one frame, then a bypassed request on eop
        cyc(1, 1, 1, 0, 0, 2'd0, 2'd0);
        cyc(0, 0, 0, 0, 1, 2'd1, 2'd0);
        cyc(0, 0, 0, 0, 1, 2'd3, 2'd0);
        cyc(1, 1, 0, 1, 0, 2'd0, 2'd0);
        chk("t2_last_req", filter_num, 3);
        cyc(1, 1, 1, 0, 0, 2'd0, 2'd0);
        cyc(1, 1, 0, 1, 1, 2'd2, 2'd0);
        chk("t2_bypass", filter_num, 2);

        // Hysteresis 2,1,2,2
        frame1(0, 2'd0, 2'd2);
        frame1(0, 2'd0, 2'd1);
        frame1(0, 2'd0, 2'd2);
        chk("t3_flag_held", freq_flag, 0);
        frame1(0, 2'd0, 2'd2);
        chk("t3_flag_set", freq_flag, 2);

        // Protocol errors
        do_reset();
        cyc(1, 1, 1, 0, 0, 2'd0, 2'd0);
        cyc(1, 1, 1, 0, 0, 2'd0, 2'd0);
        chk("t4_sop_err", proto_err, 1);
        chk("t4_sop_nocommit", frame_cnt, 0);
        cyc(1, 1, 0, 1, 0, 2'd0, 2'd0);
        chk("t4_eop_cnt", frame_cnt, 1);
        cyc(1, 1, 0, 1, 0, 2'd0, 2'd0);
        chk("t4_stray_err", proto_err, 1);
        cyc(1, 0, 0, 1, 0, 2'd0, 2'd0);
        chk("t4_noready_err", proto_err, 0);
        chk("t4_noready_done", frame_done, 0);

        // Reset mid-frame with a pending request
        cyc(1, 1, 1, 0, 0, 2'd0, 2'd0);
        cyc(0, 0, 0, 0, 1, 2'd3, 2'd0);
        do_reset();
        chk("t5_rst_cnt", frame_cnt, 0);
        chk("t5_rst_inframe", in_frame, 0);
        cyc(1, 1, 0, 1, 0, 2'd0, 2'd0);
        chk("t5_orphan_eop", proto_err, 1);
        cyc(1, 1, 1, 0, 0, 2'd0, 2'd0);
        cyc(1, 1, 0, 1, 0, 2'd0, 2'd0);
        chk("t5_req_lost", filter_num, 0);
        chk("t5_cnt", frame_cnt, 1);

        // Auto-cycle
        do_reset();
        auto_mode = 1;
        for (int f = 1; f <= 9; f++) begin
            frame1(0, 2'd0, 2'd0);
            if (f % 3 == 0) chk("t6_auto", filter_num, AUTO ? f / 3 : 0);
        end
        do_reset();
        for (int f = 1; f <= 3; f++) frame1(0, 2'd0, 2'd0);
        chk("t6_step1", filter_num, AUTO ? 1 : 0);
        frame1(1, 2'd0, 2'd0);
        frame1(0, 2'd0, 2'd0);
        frame1(0, 2'd0, 2'd0);
        chk("t6_restart", filter_num, 0);
        frame1(0, 2'd0, 2'd0);
        chk("t6_after_req", filter_num, AUTO ? 1 : 0);

        // Randomized traffic
        do_reset();
        begin
            logic [1:0] fl;
            fl = 2'd0;
            for (int n = 0; n < 3000; n++) begin
                if ($urandom_range(99) < 30) fl = 2'($urandom_range(3));
                auto_mode = AUTO ? 1'b1 : 1'($urandom_range(1));
                reset = ($urandom_range(199) == 0);
                cyc($urandom_range(99) < 70, $urandom_range(99) < 70,
                    $urandom_range(99) < 20, $urandom_range(99) < 25,
                    $urandom_range(99) < 10, 2'($urandom_range(3)), fl);
            end
            reset = 0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/frame_sync_filter_ctrl.md
# frame_sync_filter_ctrl

Configuration controller for the video filter mux: it owns `filter_num` and `freq_flag` and changes them only at frame boundaries. Button requests and the audio `freq_flag` are absorbed at any time. New values are committed only after an end-of-packet beat is accepted, so no frame is ever processed by two filters or two strengths. It sits beside the filter mux and passively monitors the mux's input stream handshake. An optional auto-cycle mode steps through the filters every N frames.

## Interface
- `FRAMES_PER_STEP`, default 60: completed frames per auto-cycle step, ≥1.
- `FLAG_HOLD_FRAMES`, default 2: consecutive boundaries `freq_flag_in` must hold one value before it is committed, ≥1.
- `clk`  in  1  single clock.
- `reset`  in  1  synchronous, active-high.
- `req_valid`  in  1  one-cycle filter change request.
- `req_filter`  in  2  requested filter: 0 COLOUR, 1 BLUR, 2 BRIGHTNESS, 3 EDGES.
- `auto_mode`  in  1  enables auto-cycle (only with macro).
- `freq_flag_in`  in  2  raw audio band flag.
- `mon_valid`, `mon_ready`, `mon_sop`, `mon_eop`  in  1 each  observed stream handshake at the filter mux input.
- `filter_num`  out  2  committed filter selection.
- `freq_flag`  out  2  committed strength flag.
- `in_frame`  out  1  high between an accepted sop and its accepted eop.
- `frame_done`  out  1  one-cycle pulse; a frame just completed.
- `proto_err`  out  1  one-cycle pulse; a framing violation occurred.
- `frame_cnt`  out  16  completed frames, wraps at 65535→0.

## Operation
- A beat is accepted when `mon_valid && mon_ready`. Beats with any other handshake are ignored completely.
- The FSM has two states:
  - GAP (reset state): an accepted sop → FRAME.
  - FRAME: an accepted eop → GAP, and a commit occurs on that same edge.
  - An accepted beat with both sop and eop, in GAP, is a one-beat frame. It commits and the FSM stays in GAP.
- Framing violations pulse `proto_err` and leave the FSM state unchanged:
  - sop accepted while in FRAME: no commit.
  - eop accepted while in GAP without sop: no commit.
- Pending request register:
  - `req_valid` loads `req_filter` and sets `pend_v`; a later request overwrites an earlier one.
  - A request arriving in the same cycle as a commit is included in that commit (bypass).
- The commit priority for `filter_num` is:
  1. A pending request takes `filter_num` ← pending value, clears `pend_v`, and clears the step counter.
  2. Otherwise, if auto-cycle is active and the step counter equals `FRAMES_PER_STEP-1`: `filter_num` ← `filter_num+1` (3 wraps to 0) and the step counter clears.
  3. Otherwise the step counter increments.
- The commit also runs the `freq_flag` hysteresis:
  - Sample `freq_flag_in`. If it equals the candidate, the hold counter increments (saturating); otherwise candidate ← sample and hold ← 1.
  - When hold ≥ `FLAG_HOLD_FRAMES`, `freq_flag` ← candidate.
  - With `FLAG_HOLD_FRAMES`=1, every boundary updates `freq_flag`.
- Every commit increments `frame_cnt` and pulses `frame_done`.

## Timing
- Reset values: `filter_num`=0, `freq_flag`=0, `in_frame`=0, `frame_done`=0, `proto_err`=0, `frame_cnt`=0. Internally the state is GAP, `pend_v`=0, step counter=0, hold counter=0, and candidate=0.
- All outputs are registered. For an eop accepted at edge N, new `filter_num`/`freq_flag` are visible from cycle N+1, so a sop presented in cycle N+1 already sees the new configuration.
- `in_frame` rises the cycle after the sop is accepted and falls the cycle after the eop is accepted.
- Outside a commit, `filter_num` and `freq_flag` never change. This holds regardless of `req_valid`, `freq_flag_in`, or `auto_mode` activity.
- Reset asserted mid-frame forces all reset values on the next edge. Any pending request is discarded. The rest of the interrupted frame is treated as described under Operation: its eop is seen in GAP and raises `proto_err`.
- The block never drives backpressure.

## Configuration
- `FILTER_AUTO_CYCLE_EN` defined: the step counter and auto-advance logic are compiled in and `auto_mode` is honoured.
- Not defined: the step counter is removed, `auto_mode` is ignored, and `filter_num` changes only through requests.

## Structure
- Package `filter_ctrl_pkg` holds:
  - `filter_t` enum (COLOUR=0, BLUR=1, BRIGHTNESS=2, EDGES=3), shared with the filter mux;
  - `ctrl_state_t` (GAP, FRAME);
  - `FRAME_CNT_W`=16.
- Sub-module `flag_hysteresis` contains the candidate and hold-counter logic. It has a commit strobe input and `FLAG_HOLD_FRAMES` as a parameter.

## Test plan
- Request mid-frame: req BLUR during FRAME → `filter_num` stays 0 until the cycle after eop, then 1. `frame_cnt`=1 and `frame_done` pulses once.
- Two requests in one frame (BLUR then EDGES), and a request in the same cycle as eop → committed values are 3, then the bypassed value, at consecutive boundaries.
- Hysteresis with `FLAG_HOLD_FRAMES`=2: `freq_flag_in` =2,1,2,2 across four boundaries → `freq_flag` stays 0, then becomes 2 only after the fourth boundary.
- Auto-cycle with `FRAMES_PER_STEP`=3 and `auto_mode`=1: nine frames → `filter_num` sequence 0→1→2→3 at frames 3, 6, 9. A request at frame 4 resets the step counter. Without the macro, nothing advances.
- Protocol errors: sop in FRAME → `proto_err` pulse, no commit. Stray eop in GAP → `proto_err` pulse. `mon_valid` with `mon_ready`=0 on an eop → no effect.
- Reset mid-frame with a pending request → all outputs return to 0, the pending request is lost, and the next clean frame commits nothing.
